// File: rtl/ir_ac_frame_rx_if.sv
// ir_ac_frame_rx_if: IR air-conditioner frame receiver signal bundle.
//   ir_in        demodulated IR line (0 = mark, 1 = space)
//   data35       last valid 35-bit block, first-received bit in [34]
//   data32       last valid 32-bit block, first-received bit in [31]
//   frame_valid  one-cycle strobe, data35/data32 updated in the same cycle
//   frame_err    one-cycle strobe on a protocol violation
//   err_code     cause of last error (1 leader, 2 bit mark, 3 bit space, 4 connect, 5 stop)
//   busy         receiver is inside a frame
// master: the receiver; slave: the pin driver / consumer side.
interface ir_ac_frame_rx_if;
  logic        ir_in;
  logic [34:0] data35;
  logic [31:0] data32;
  logic        frame_valid;
  logic        frame_err;
  logic [2:0]  err_code;
  logic        busy;

  modport master (
    input  ir_in,
    output data35, data32, frame_valid, frame_err, err_code, busy
  );

  modport slave (
    output ir_in,
    input  data35, data32, frame_valid, frame_err, err_code, busy
  );
endinterface

// File: rtl/ir_ac_frame_rx.sv
// ir_ac_frame_rx: measures mark/space durations on the demodulated IR line and
// decodes leader, 35-bit block, connect gap, 32-bit block and stop mark.
// Ports:
//   clk  system clock
//   rst  synchronous, active-low reset
//   bus  ir_ac_frame_rx_if.master (ir_in in; data35, data32, frame_valid,
//        frame_err, err_code, busy out)
// Optional macro IR_RX_GLITCH_FILTER_EN: lvl only follows the synchronized
// input once it has held a new value for FILT_CYC consecutive cycles.
module ir_ac_frame_rx #(
  parameter int unsigned T_LEAD_MARK_MIN  = 800000,
  parameter int unsigned T_LEAD_MARK_MAX  = 1000000,
  parameter int unsigned T_LEAD_SPACE_MIN = 350000,
  parameter int unsigned T_LEAD_SPACE_MAX = 550000,
  parameter int unsigned T_MARK_MIN       = 40000,
  parameter int unsigned T_MARK_MAX       = 110000,
  parameter int unsigned T_SPACE_MIN      = 20000,
  parameter int unsigned T_BIT_THR        = 100000,
  parameter int unsigned T_SPACE_MAX      = 200000,
  parameter int unsigned T_CONN_MIN       = 1800000,
  parameter int unsigned T_CONN_MAX       = 2300000,
  parameter int unsigned FILT_CYC         = 2000
) (
  input logic             clk,
  input logic             rst,
  ir_ac_frame_rx_if.master bus
);

  localparam int unsigned CW = 22;
  localparam int unsigned BW = 6;

  localparam logic [CW-1:0] LM_MIN = CW'(T_LEAD_MARK_MIN);
  localparam logic [CW-1:0] LM_MAX = CW'(T_LEAD_MARK_MAX);
  localparam logic [CW-1:0] LS_MIN = CW'(T_LEAD_SPACE_MIN);
  localparam logic [CW-1:0] LS_MAX = CW'(T_LEAD_SPACE_MAX);
  localparam logic [CW-1:0] M_MIN  = CW'(T_MARK_MIN);
  localparam logic [CW-1:0] M_MAX  = CW'(T_MARK_MAX);
  localparam logic [CW-1:0] S_MIN  = CW'(T_SPACE_MIN);
  localparam logic [CW-1:0] S_THR  = CW'(T_BIT_THR);
  localparam logic [CW-1:0] S_MAX  = CW'(T_SPACE_MAX);
  localparam logic [CW-1:0] C_MIN  = CW'(T_CONN_MIN);
  localparam logic [CW-1:0] C_MAX  = CW'(T_CONN_MAX);

  if (FILT_CYC == 0) begin : g_filt_chk
    $error("FILT_CYC must be at least 1");
  end

  typedef enum logic [2:0] {
    IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, CONN_MARK, CONN_SPACE, STOP_MARK
  } state_t;

  state_t          state, state_nxt;
  logic            sync1, sync2, lvl, lvl_d, lvl_edge;
  logic [CW-1:0]   cnt;
  logic [BW-1:0]   bcnt;
  logic            phase;
  logic [34:0]     sr35;
  logic [31:0]     sr32;
  logic [CW-1:0]   win_lo, win_hi;
  logic [2:0]      code;
  logic            shift_en, start, set_phase, load, err, bit_val;

  // Two-flop synchronizer, idles at space
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= bus.ir_in;
      sync2 <= sync1;
    end
  end

`ifdef IR_RX_GLITCH_FILTER_EN
  localparam int unsigned FW = $clog2(FILT_CYC + 1);
  logic [FW-1:0] fcnt;

  // Accept a new level only after FILT_CYC stable cycles
  always_ff @(posedge clk) begin
    if (!rst) begin
      lvl  <= 1'b1;
      fcnt <= '0;
    end else if (sync2 == lvl) begin
      fcnt <= '0;
    end else if (fcnt == FW'(FILT_CYC - 1)) begin
      lvl  <= sync2;
      fcnt <= '0;
    end else begin
      fcnt <= fcnt + FW'(1);
    end
  end
`else
  assign lvl = sync2;
`endif

  assign lvl_edge = lvl ^ lvl_d;
  assign bit_val  = (cnt >= S_THR);

  // Duration counter: restarts on each edge, saturates at all-ones
  always_ff @(posedge clk) begin
    if (!rst) begin
      lvl_d <= 1'b1;
      cnt   <= '0;
    end else begin
      lvl_d <= lvl;
      if (lvl_edge)
        cnt <= '0;
      else if (cnt != '1)
        cnt <= cnt + CW'(1);
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next state: window per state, edge-in-window advances, otherwise error
  always_comb begin
    state_nxt = state;
    win_lo    = '0;
    win_hi    = '1;
    code      = 3'd0;
    shift_en  = 1'b0;
    start     = 1'b0;
    set_phase = 1'b0;
    load      = 1'b0;
    err       = 1'b0;

    case (state)
      LEAD_MARK:  begin win_lo = LM_MIN; win_hi = LM_MAX; code = 3'd1; end
      LEAD_SPACE: begin win_lo = LS_MIN; win_hi = LS_MAX; code = 3'd1; end
      BIT_MARK:   begin win_lo = M_MIN;  win_hi = M_MAX;  code = 3'd2; end
      BIT_SPACE:  begin win_lo = S_MIN;  win_hi = S_MAX;  code = 3'd3; end
      CONN_MARK:  begin win_lo = M_MIN;  win_hi = M_MAX;  code = 3'd4; end
      CONN_SPACE: begin win_lo = C_MIN;  win_hi = C_MAX;  code = 3'd4; end
      STOP_MARK:  begin win_lo = M_MIN;  win_hi = M_MAX;  code = 3'd5; end
      default:    ;
    endcase

    if (state == IDLE) begin
      // Only a fresh falling edge starts a leader
      if (lvl_edge && !lvl) begin
        state_nxt = LEAD_MARK;
        start     = 1'b1;
      end
    end else if (lvl_edge) begin
      if (cnt >= win_lo && cnt <= win_hi) begin
        case (state)
          LEAD_MARK:  state_nxt = LEAD_SPACE;
          LEAD_SPACE: state_nxt = BIT_MARK;
          BIT_MARK:   state_nxt = BIT_SPACE;
          BIT_SPACE: begin
            shift_en = 1'b1;
            if (!phase && bcnt == BW'(34))     state_nxt = CONN_MARK;
            else if (phase && bcnt == BW'(31)) state_nxt = STOP_MARK;
            else                               state_nxt = BIT_MARK;
          end
          CONN_MARK:  state_nxt = CONN_SPACE;
          CONN_SPACE: begin
            set_phase = 1'b1;
            state_nxt = BIT_MARK;
          end
          STOP_MARK: begin
            load      = 1'b1;
            state_nxt = IDLE;
          end
          default:    state_nxt = IDLE;
        endcase
      end else begin
        err = 1'b1;
      end
    end else if (cnt > win_hi) begin
      err = 1'b1;
    end

    if (err) state_nxt = IDLE;
  end

  // Bit assembly and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      bcnt            <= '0;
      phase           <= 1'b0;
      sr35            <= '0;
      sr32            <= '0;
      bus.data35      <= '0;
      bus.data32      <= '0;
      bus.frame_valid <= 1'b0;
      bus.frame_err   <= 1'b0;
      bus.err_code    <= '0;
      bus.busy        <= 1'b0;
    end else begin
      bus.frame_valid <= load;
      bus.frame_err   <= err;
      bus.busy        <= (state_nxt != IDLE);
      if (err) bus.err_code <= code;

      if (start || set_phase) bcnt <= '0;
      else if (shift_en)      bcnt <= bcnt + BW'(1);

      if (start)          phase <= 1'b0;
      else if (set_phase) phase <= 1'b1;

      if (shift_en) begin
        if (phase) sr32 <= {sr32[30:0], bit_val};
        else       sr35 <= {sr35[33:0], bit_val};
      end

      if (load) begin
        bus.data35 <= sr35;
        bus.data32 <= sr32;
      end
    end
  end

endmodule
